frame_config_writer: RTL
========================

// Module: frame_config_writer
// PURPOSE
//  Drives the configuration side of the fabric's frame interface: accepts one frame command
//  (header + one data word per row) over a valid/ready stream, presents the words on the
//  per-row FrameData buses, then pulses the selected FrameStrobe bit of the selected column.
//  Sits between the bitstream loader and the top row of terminal tiles that buffer FrameStrobe.
// PARAMETERS
//  NumColumns       4   fabric columns; one MaxFramesPerCol-wide strobe group per column
//  NumRows          4   fabric rows; one FrameBitsPerRow-wide data word per row
//  MaxFramesPerCol  20  frames per column (strobe bits per column), <=256
//  FrameBitsPerRow  32  data word width, >=16 (header fields need 16 bits)
//  StrobeCycles     2   cycles FrameStrobe is held high, >=1
// PORTS
//  UserCLK       in   1                           clock
//  reset         in   1                           synchronous, active-high reset
//  s_valid       in   1                           stream word valid
//  s_ready       out  1                           stream word accepted when s_valid&&s_ready
//  s_data        in   FrameBitsPerRow             header or data word
//  FrameData     out  NumRows*FrameBitsPerRow     row r word at [r*FrameBitsPerRow +: FrameBitsPerRow]
//  FrameStrobe   out  NumColumns*MaxFramesPerCol  column c frame f at bit c*MaxFramesPerCol+f
//  busy          out  1                           state != IDLE
//  err           out  1                           sticky: header addressed a non-existent column/frame
//  err_clear     in   1                           clears err (single-cycle pulse)
//  frames_done   out  16                          count of completed strobes, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: state=IDLE; FrameData=0, FrameStrobe=0, busy=0, err=0, frames_done=0, s_ready=1.
//  - Header word: [7:0]=frame index f, [15:8]=column index c, upper bits ignored.
//  - FSM: IDLE -> LOAD on header accept (row_cnt=0; latch c,f; bad = c>=NumColumns || f>=MaxFramesPerCol).
//    LOAD: each accept writes s_data into FrameData row row_cnt (unless bad), row_cnt++;
//    on accept of row NumRows-1: bad ? IDLE (set err) : SETUP.
//    SETUP (1 cycle) -> STROBE (StrobeCycles cycles) -> HOLD (1 cycle) -> IDLE.
//  - s_ready = (state==IDLE || state==LOAD); decoded from state only, never from s_valid.
//  - FrameStrobe: only bit c*MaxFramesPerCol+f high, and only while state==STROBE; else all 0.
//  - FrameData registered; stable from SETUP through HOLD; retains last frame after HOLD.
//  - Latency (back-to-back beats, header accepted at edge 0): last data at edge NumRows,
//    SETUP cycle NumRows..NumRows+1, strobe high for StrobeCycles cycles from edge NumRows+1,
//    s_ready returns 1 after edge NumRows+StrobeCycles+2.
//  - Gaps in s_valid during LOAD stall row_cnt; no timeout.
//  - Bad header: data words still consumed (stream stays aligned), FrameData untouched, no strobe,
//    frames_done unchanged; err set on the edge leaving LOAD.
//  - err_clear and a new error on same edge: err stays 1 (set wins).
//  - frames_done increments on the STROBE->HOLD edge; 16-bit wrap.
//  - Reset mid-frame (any state): FrameStrobe drops to 0 at that edge, partial frame discarded,
//    FrameData cleared, next accepted word is treated as a header.
// TESTING
//  1 Defaults: header c=2,f=5 then rows 0xA0..0xA3 back to back -> FrameData rows = A0..A3,
//    FrameStrobe bit 45 high exactly 2 cycles starting 1 cycle after last beat, frames_done=1.
//  2 Stalls: same frame with s_valid low 3 cycles between every beat -> identical FrameData and
//    single 2-cycle strobe; s_ready never low during LOAD.
//  3 Bad header c=4,f=0 (and separately c=0,f=20) + 4 words -> no strobe, FrameData unchanged,
//    err=1, next valid frame completes normally; err_clear pulse -> err=0.
//  4 Assert reset during STROBE of c=0,f=0 -> FrameStrobe=0 next cycle, FrameData=0, busy=0;
//    following header+4 words processed as a fresh frame.
//  5 Preload frames_done to 0xFFFF via 65535 short frames (or force) then one frame -> wraps to 0.
//  6 Continuous s_valid=1 stream of 3 frames -> s_ready low exactly StrobeCycles+2 cycles per
//    frame, strobes non-overlapping, each exactly one bit.

Source files
------------

// File: rtl/frame_config_writer.sv
// Frame configuration writer: takes a header plus one word per row from a valid/ready stream,
// drives the row FrameData buses, then pulses a single FrameStrobe bit for the addressed column.
module frame_config_writer #(
  parameter int NumColumns      = 4,
  parameter int NumRows         = 4,
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int StrobeCycles    = 2
) (
  input  logic                                  UserCLK,
  input  logic                                  reset,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [FrameBitsPerRow-1:0]            s_data,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  err,
  input  logic                                  err_clear,
  output logic [15:0]                           frames_done
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int CntW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam int NumStrobes = NumColumns * MaxFramesPerCol;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t                                  state_q;
  logic [RowW-1:0]                         row_q;
  logic [7:0]                              col_q;
  logic [7:0]                              frm_q;
  logic                                    bad_q;
  logic [CntW-1:0]                         cnt_q;
  logic [NumRows-1:0][FrameBitsPerRow-1:0] data_q;
  logic [NumStrobes-1:0]                   strobe_q;
  logic                                    err_q;
  logic [15:0]                             done_q;

  logic                  accept;
  logic                  hdr_bad;
  logic [NumStrobes-1:0] strobe_sel;

  assign accept  = s_valid && s_ready;
  assign hdr_bad = ({1'b0, s_data[15:8]} >= 9'(NumColumns)) ||
                   ({1'b0, s_data[7:0]}  >= 9'(MaxFramesPerCol));

  // One-hot decode of the latched column/frame address into the flat strobe vector.
  generate
    for (genvar gi = 0; gi < NumColumns; gi++) begin : g_col
      for (genvar gj = 0; gj < MaxFramesPerCol; gj++) begin : g_frm
        assign strobe_sel[gi*MaxFramesPerCol + gj] = (col_q == 8'(gi)) && (frm_q == 8'(gj));
      end
    end
  endgenerate

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      frm_q    <= '0;
      bad_q    <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
      done_q   <= '0;
    end else begin
      if (err_clear) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            col_q   <= s_data[15:8];
            frm_q   <= s_data[7:0];
            bad_q   <= hdr_bad;
            row_q   <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            // A bad frame still consumes its data words so the stream stays aligned.
            if (!bad_q) data_q[row_q] <= s_data;
            if (row_q == RowW'(NumRows - 1)) begin
              if (bad_q) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= SETUP;
              end
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        SETUP: begin
          strobe_q <= strobe_sel;
          cnt_q    <= '0;
          state_q  <= STROBE;
        end
        STROBE: begin
          if (cnt_q == CntW'(StrobeCycles - 1)) begin
            strobe_q <= '0;
            done_q   <= done_q + 16'd1;
            state_q  <= HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready     = (state_q == IDLE) || (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign err         = err_q;
  assign frames_done = done_q;

endmodule
